// File: rtl/bch_decode_ctrl.sv
// Sequencing controller for the BCH decoder: syndrome -> ELP -> Chien search -> result check.
// Optional: define BCH_ZERO_SYN_BYPASS_EN to skip ELP/Chien for all-zero syndromes.
module bch_decode_ctrl #(
  parameter int unsigned C_INDWIDTH = 31,
  parameter int unsigned C_ERR_NUM  = 4,
  parameter int unsigned C_ELP_LAT  = 4,
  parameter int unsigned C_CODE_LEN = 127
) (
  input  logic                                  I_clk,
  input  logic                                  I_rst_n,
  input  logic                                  I_start,
  output logic                                  O_ready,
  output logic                                  O_syn_start,
  input  logic                                  I_syn_done,
  input  logic [C_INDWIDTH*C_ERR_NUM-1:0]       I_syndromes,
  output logic [C_INDWIDTH*C_ERR_NUM-1:0]       O_syndromes,
  output logic                                  O_syndromes_v,
  input  logic [C_INDWIDTH*(C_ERR_NUM+1)-1:0]   I_elp,
  output logic                                  O_chien_load,
  output logic                                  O_chien_en,
  output logic [$clog2(C_CODE_LEN)-1:0]         O_bit_idx,
  input  logic                                  I_chien_hit,
  output logic                                  O_done,
  output logic [$clog2(C_ERR_NUM+2)-1:0]        O_err_cnt,
  output logic                                  O_fail
);

  localparam int unsigned SYN_W = C_INDWIDTH * C_ERR_NUM;
  localparam int unsigned IDX_W = $clog2(C_CODE_LEN);
  localparam int unsigned CNT_W = $clog2(C_ERR_NUM + 2);
  localparam int unsigned LAT_W = $clog2(C_ELP_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_CODE_LEN - 1);
  localparam logic [CNT_W-1:0] HIT_MAX  = CNT_W'(C_ERR_NUM + 1);

`ifdef BCH_ZERO_SYN_BYPASS_EN
  localparam bit ZERO_SYN_BYPASS = 1'b1;
`else
  localparam bit ZERO_SYN_BYPASS = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYN, ST_ELP, ST_LOAD, ST_SEARCH, ST_CHECK, ST_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [LAT_W-1:0]   lat_cnt, lat_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [CNT_W-1:0]   hit_cnt, hit_nxt;
  logic [CNT_W-1:0]   deg, deg_nxt, deg_c;
  logic [SYN_W-1:0]   syn_nxt;
  logic [CNT_W-1:0]   err_nxt;
  logic               fail_nxt;
  logic               syn_start_nxt;
  logic               syn_v_nxt;
  logic               bypass_c;

  assign bypass_c = ZERO_SYN_BYPASS && (I_syndromes == '0);

  // Locator degree: highest nonzero coefficient index.
  always_comb begin
    deg_c = '0;
    for (int i = 0; i <= int'(C_ERR_NUM); i++) begin
      if (I_elp[i*C_INDWIDTH +: C_INDWIDTH] != '0) deg_c = CNT_W'(i);
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt     = state;
    lat_nxt       = lat_cnt;
    idx_nxt       = O_bit_idx;
    hit_nxt       = hit_cnt;
    deg_nxt       = deg;
    syn_nxt       = O_syndromes;
    err_nxt       = O_err_cnt;
    fail_nxt      = O_fail;
    syn_start_nxt = 1'b0;
    syn_v_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (I_start) begin
          state_nxt     = ST_SYN;
          syn_start_nxt = 1'b1;
          err_nxt       = '0;
          fail_nxt      = 1'b0;
          hit_nxt       = '0;
        end
      end
      ST_SYN: begin
        if (I_syn_done) begin
          syn_nxt = I_syndromes;
          if (bypass_c) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_ELP;
            syn_v_nxt = 1'b1;
            lat_nxt   = LAT_W'(C_ELP_LAT - 1);
          end
        end
      end
      ST_ELP: begin
        if (lat_cnt == '0) state_nxt = ST_LOAD;
        else               lat_nxt   = lat_cnt - LAT_W'(1);
      end
      ST_LOAD: begin
        deg_nxt   = deg_c;
        idx_nxt   = '0;
        state_nxt = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (I_chien_hit && (hit_cnt != HIT_MAX)) hit_nxt = hit_cnt + CNT_W'(1);
        if (O_bit_idx == LAST_IDX) begin
          idx_nxt   = '0;
          state_nxt = ST_CHECK;
        end else begin
          idx_nxt = O_bit_idx + IDX_W'(1);
        end
      end
      ST_CHECK: begin
        err_nxt   = hit_cnt;
        fail_nxt  = (hit_cnt != deg) || ((deg == '0) && (O_syndromes != '0));
        state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state         <= ST_IDLE;
      lat_cnt       <= '0;
      hit_cnt       <= '0;
      deg           <= '0;
      O_ready       <= 1'b1;
      O_syn_start   <= 1'b0;
      O_syndromes   <= '0;
      O_syndromes_v <= 1'b0;
      O_chien_load  <= 1'b0;
      O_chien_en    <= 1'b0;
      O_bit_idx     <= '0;
      O_done        <= 1'b0;
      O_err_cnt     <= '0;
      O_fail        <= 1'b0;
    end else begin
      state         <= state_nxt;
      lat_cnt       <= lat_nxt;
      hit_cnt       <= hit_nxt;
      deg           <= deg_nxt;
      O_ready       <= (state_nxt == ST_IDLE);
      O_syn_start   <= syn_start_nxt;
      O_syndromes   <= syn_nxt;
      O_syndromes_v <= syn_v_nxt;
      O_chien_load  <= (state_nxt == ST_LOAD);
      O_chien_en    <= (state_nxt == ST_SEARCH);
      O_bit_idx     <= idx_nxt;
      O_done        <= (state_nxt == ST_DONE);
      O_err_cnt     <= err_nxt;
      O_fail        <= fail_nxt;
    end
  end

endmodule

// File: tb/tb_bch_decode_ctrl.sv
// Directed bench for bch_decode_ctrl with default parameters (t=4, L=4, N=127).
module tb_bch_decode_ctrl;

  localparam int W        = 31;
  localparam int FULL_LAT = 4 + 127 + 3;  // syn_done cycle to O_done on the full path

  logic           I_clk = 1'b0;
  logic           I_rst_n = 1'b1;
  logic           I_start = 1'b0;
  logic           O_ready;
  logic           O_syn_start;
  logic           I_syn_done = 1'b0;
  logic [123:0]   I_syndromes = '0;
  logic [123:0]   O_syndromes;
  logic           O_syndromes_v;
  logic [154:0]   I_elp = '0;
  logic           O_chien_load;
  logic           O_chien_en;
  logic [6:0]     O_bit_idx;
  logic           I_chien_hit = 1'b0;
  logic           O_done;
  logic [2:0]     O_err_cnt;
  logic           O_fail;

  bch_decode_ctrl dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_start(I_start), .O_ready(O_ready),
    .O_syn_start(O_syn_start), .I_syn_done(I_syn_done), .I_syndromes(I_syndromes),
    .O_syndromes(O_syndromes), .O_syndromes_v(O_syndromes_v), .I_elp(I_elp),
    .O_chien_load(O_chien_load), .O_chien_en(O_chien_en), .O_bit_idx(O_bit_idx),
    .I_chien_hit(I_chien_hit), .O_done(O_done), .O_err_cnt(O_err_cnt), .O_fail(O_fail)
  );

  always #5 I_clk = ~I_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_cnt, load_cnt, synv_cnt, done_cnt, done_cyc, sst_cnt;
  logic [126:0] hit_mask = '0;

  localparam logic [123:0] SYN_A = 124'h0000_0123_4567_89ab_cdef_0042;
  localparam logic [123:0] SYN_B = 124'h7777_0000_1111_0000_2222;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [154:0] mk_elp(input logic [W-1:0] c0, c1, c2, c3, c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  // Advance one cycle, observe outputs, and act as the Chien root detector.
  task automatic tick();
    @(negedge I_clk);
    cyc++;
    if (O_chien_en)    en_cnt++;
    if (O_chien_load)  load_cnt++;
    if (O_syndromes_v) synv_cnt++;
    if (O_syn_start)   sst_cnt++;
    if (O_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    I_chien_hit = O_chien_en && hit_mask[O_bit_idx];
  endtask

  task automatic run_decode(input string tag, input logic [123:0] syn, input logic [154:0] elp,
                            input logic [126:0] mask, input int exp_err, input int exp_fail,
                            input int exp_lat, input int exp_en, input int exp_load,
                            input int exp_synv, input bit stray);
    int s;
    hit_mask = mask;
    I_elp    = elp;
    en_cnt = 0; load_cnt = 0; synv_cnt = 0; done_cnt = 0; done_cyc = 0; sst_cnt = 0;
    I_start = 1'b1;
    tick();
    I_start = 1'b0;
    check({tag, "/syn_start"}, O_syn_start, 1);
    check({tag, "/ready_busy"}, O_ready, 0);
    I_syndromes = syn;
    I_syn_done  = 1'b1;
    s = cyc;
    tick();
    I_syn_done  = 1'b0;
    I_syndromes = ~syn;
    for (int k = 0; k < 300 && done_cnt == 0; k++) begin
      I_syn_done = stray && (cyc == s + 2);
      I_start    = stray && (cyc == s + 60);
      tick();
    end
    I_syn_done = 1'b0;
    I_start    = 1'b0;
    check({tag, "/done_seen"}, done_cnt, 1);
    check({tag, "/done_lat"}, done_cyc - s, exp_lat);
    check({tag, "/err_cnt"}, O_err_cnt, exp_err);
    check({tag, "/fail"}, O_fail, exp_fail);
    check({tag, "/en_cycles"}, en_cnt, exp_en);
    check({tag, "/load_pulses"}, load_cnt, exp_load);
    check({tag, "/synv_pulses"}, synv_cnt, exp_synv);
    tick();
    check({tag, "/ready_back"}, O_ready, 1);
    repeat (3) tick();
    check({tag, "/single_done"}, done_cnt, 1);
    check({tag, "/single_start"}, sst_cnt, 1);
    check({tag, "/err_hold"}, O_err_cnt, exp_err);
    check({tag, "/syn_kept"}, O_syndromes, syn);
  endtask

  initial begin
    logic [126:0] m;
    #2 I_rst_n = 1'b0;
    tick();
    tick();
    check("rst/ready", O_ready, 1);
    check("rst/done", O_done, 0);
    check("rst/err_cnt", O_err_cnt, 0);
    check("rst/fail", O_fail, 0);
    check("rst/chien_en", O_chien_en, 0);
    check("rst/syndromes", O_syndromes, 0);
    I_rst_n = 1'b1;
    tick();

    m = '0; m[5] = 1'b1; m[90] = 1'b1;
    run_decode("two_err", SYN_A, mk_elp(31'h1, 31'h2a, 31'h7, 31'h0, 31'h0), m,
               2, 0, FULL_LAT, 127, 1, 1, 1'b0);

    m = '0; m[0] = 1'b1; m[126] = 1'b1;
    run_decode("deg_mismatch", SYN_B, mk_elp(31'h1, 31'h3, 31'h0, 31'h55, 31'h0), m,
               2, 1, FULL_LAT, 127, 1, 1, 1'b0);

    m = '0; m[3] = 1'b1; m[10] = 1'b1; m[20] = 1'b1; m[30] = 1'b1;
    m[40] = 1'b1; m[50] = 1'b1; m[60] = 1'b1;
    run_decode("saturate", SYN_A, mk_elp(31'h1, 31'h1, 31'h1, 31'h1, 31'h9), m,
               5, 1, FULL_LAT, 127, 1, 1, 1'b0);

`ifdef BCH_ZERO_SYN_BYPASS_EN
    run_decode("zero_syn", '0, mk_elp(31'h1, 31'h0, 31'h0, 31'h0, 31'h0), '0,
               0, 0, 1, 0, 0, 0, 1'b0);
`else
    run_decode("zero_syn", '0, mk_elp(31'h1, 31'h0, 31'h0, 31'h0, 31'h0), '0,
               0, 0, FULL_LAT, 127, 1, 1, 1'b0);
`endif

    run_decode("deg0_nonzero_syn", SYN_B, mk_elp(31'h1, 31'h0, 31'h0, 31'h0, 31'h0), '0,
               0, 1, FULL_LAT, 127, 1, 1, 1'b0);

    m = '0; m[5] = 1'b1; m[90] = 1'b1;
    run_decode("stray_inputs", SYN_A, mk_elp(31'h1, 31'h2a, 31'h7, 31'h0, 31'h0), m,
               2, 0, FULL_LAT, 127, 1, 1, 1'b1);

    // Reset while the Chien search is at index 40.
    hit_mask = '0; hit_mask[10] = 1'b1;
    I_elp = mk_elp(31'h1, 31'h4, 31'h0, 31'h0, 31'h0);
    I_start = 1'b1;
    tick();
    I_start = 1'b0;
    I_syndromes = SYN_A;
    I_syn_done  = 1'b1;
    tick();
    I_syn_done = 1'b0;
    for (int k = 0; k < 200 && !(O_chien_en && O_bit_idx == 7'd40); k++) tick();
    check("rst_mid/reached_idx40", O_bit_idx, 40);
    I_rst_n = 1'b0;
    #1;
    check("rst_mid/chien_en", O_chien_en, 0);
    check("rst_mid/ready", O_ready, 1);
    check("rst_mid/err_cnt", O_err_cnt, 0);
    check("rst_mid/bit_idx", O_bit_idx, 0);
    check("rst_mid/syndromes", O_syndromes, 0);
    tick();
    I_rst_n = 1'b1;
    tick();

    m = '0; m[5] = 1'b1; m[90] = 1'b1;
    run_decode("after_rst", SYN_A, mk_elp(31'h1, 31'h2a, 31'h7, 31'h0, 31'h0), m,
               2, 0, FULL_LAT, 127, 1, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
